// File: rtl/riscv_hazard_ctrl_mc_pkg.sv
// Shared encodings and sizing helpers for the multi-cycle hazard controller.
package riscv_hazard_ctrl_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MC_BUSY  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Down-counter width: enough for max(MC_LAT, MEM_LAT)-1, never zero bits.
    function automatic int unsigned cnt_width(input int unsigned mc_lat,
                                              input int unsigned mem_lat);
        int unsigned m;
        m = (mc_lat > mem_lat) ? mc_lat : mem_lat;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/riscv_hazard_fwd_sel.sv
// Single-source forwarding select: M result beats W result beats regfile.
module riscv_hazard_fwd_sel
    import riscv_hazard_ctrl_mc_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1
) (
    input  logic [REG_AW-1:0] i_rs_addr_e,
    input  logic [REG_AW-1:0] i_rd_addr_m,
    input  logic              i_reg_wr_en_m,
    input  logic [REG_AW-1:0] i_rd_addr_w,
    input  logic              i_reg_wr_en_w,
    output logic [1:0]        o_fwd_sel
);

    logic [1:0] w_sel;

    // Priority compare; x0 never forwards since it is hardwired to zero.
    always_comb begin
        w_sel = FWD_RF;
        if ((i_rs_addr_e != '0) && i_reg_wr_en_m && (i_rs_addr_e == i_rd_addr_m)) begin
            w_sel = FWD_M;
        end else if ((i_rs_addr_e != '0) && i_reg_wr_en_w && (i_rs_addr_e == i_rd_addr_w)) begin
            w_sel = FWD_W;
        end
    end

    assign o_fwd_sel = (FWD_EN != 0) ? w_sel : FWD_RF;

endmodule

// File: rtl/riscv_hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32I pipeline with multi-cycle E and M support.
module riscv_hazard_ctrl_mc
    import riscv_hazard_ctrl_mc_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MC_LAT  = 8,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned FWD_EN  = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [REG_AW-1:0] i_hazard_rs1_addr_d,
    input  logic [REG_AW-1:0] i_hazard_rs2_addr_d,
    input  logic [REG_AW-1:0] i_hazard_rs1_addr_e,
    input  logic [REG_AW-1:0] i_hazard_rs2_addr_e,
    input  logic [REG_AW-1:0] i_hazard_rd_addr_e,
    input  logic              i_hazard_reg_wr_en_e,
    input  logic              i_hazard_load_e,
    input  logic              i_hazard_mc_op_e,
    input  logic              i_hazard_branch_taken_e,
    input  logic [REG_AW-1:0] i_hazard_rd_addr_m,
    input  logic              i_hazard_reg_wr_en_m,
    input  logic              i_hazard_mem_req_m,
    input  logic [REG_AW-1:0] i_hazard_rd_addr_w,
    input  logic              i_hazard_reg_wr_en_w,
    input  logic              i_hazard_cnt_clr,
    output logic              o_hazard_stall_f,
    output logic              o_hazard_stall_d,
    output logic              o_hazard_stall_e,
    output logic              o_hazard_stall_m,
    output logic              o_hazard_flush_d,
    output logic              o_hazard_flush_e,
    output logic              o_hazard_flush_m,
    output logic [1:0]        o_hazard_forward_ae,
    output logic [1:0]        o_hazard_forward_be,
    output logic              o_hazard_mc_done,
    output logic              o_hazard_busy,
    output logic [CNT_W-1:0]  o_hazard_stall_cnt
);

    localparam int unsigned   CW        = cnt_width(MC_LAT, MEM_LAT);
    localparam bit            MEM_MULTI = (MEM_LAT > 1);
    localparam bit            MC_MULTI  = (MC_LAT > 1);
    localparam logic [CW-1:0] MEM_LOAD  = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] MC_LOAD   = CW'(MC_LAT - 1);

    hz_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_mc_done;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs1_d_nz, w_rs2_d_nz;
    logic w_rs1_raw, w_rs2_raw;
    logic w_raw_d, w_lwstall;
    logic w_mem_entry, w_mc_entry;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_m;

    // Forwarding selects for the two E-stage operands.
    riscv_hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .i_rs_addr_e   (i_hazard_rs1_addr_e),
        .i_rd_addr_m   (i_hazard_rd_addr_m),
        .i_reg_wr_en_m (i_hazard_reg_wr_en_m),
        .i_rd_addr_w   (i_hazard_rd_addr_w),
        .i_reg_wr_en_w (i_hazard_reg_wr_en_w),
        .o_fwd_sel     (o_hazard_forward_ae)
    );

    riscv_hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .i_rs_addr_e   (i_hazard_rs2_addr_e),
        .i_rd_addr_m   (i_hazard_rd_addr_m),
        .i_reg_wr_en_m (i_hazard_reg_wr_en_m),
        .i_rd_addr_w   (i_hazard_rd_addr_w),
        .i_reg_wr_en_w (i_hazard_reg_wr_en_w),
        .o_fwd_sel     (o_hazard_forward_be)
    );

    // RAW against any in-flight writer; only a hazard when forwarding is off.
    assign w_rs1_d_nz = (i_hazard_rs1_addr_d != '0);
    assign w_rs2_d_nz = (i_hazard_rs2_addr_d != '0);
    assign w_rs1_raw  = w_rs1_d_nz &&
                        ((i_hazard_reg_wr_en_e && (i_hazard_rs1_addr_d == i_hazard_rd_addr_e)) ||
                         (i_hazard_reg_wr_en_m && (i_hazard_rs1_addr_d == i_hazard_rd_addr_m)) ||
                         (i_hazard_reg_wr_en_w && (i_hazard_rs1_addr_d == i_hazard_rd_addr_w)));
    assign w_rs2_raw  = w_rs2_d_nz &&
                        ((i_hazard_reg_wr_en_e && (i_hazard_rs2_addr_d == i_hazard_rd_addr_e)) ||
                         (i_hazard_reg_wr_en_m && (i_hazard_rs2_addr_d == i_hazard_rd_addr_m)) ||
                         (i_hazard_reg_wr_en_w && (i_hazard_rs2_addr_d == i_hazard_rd_addr_w)));
    assign w_raw_d    = (FWD_EN == 0) && (w_rs1_raw || w_rs2_raw);

    // Load-use: loaded value is not ready to forward to the next instruction.
    assign w_lwstall  = i_hazard_load_e && (i_hazard_rd_addr_e != '0) &&
                        ((i_hazard_rs1_addr_d == i_hazard_rd_addr_e) ||
                         (i_hazard_rs2_addr_d == i_hazard_rd_addr_e));

    // FSM entry; memory wins because the M instruction is older than E.
    assign w_mem_entry = (r_state == ST_IDLE) && MEM_MULTI && i_hazard_mem_req_m;
    assign w_mc_entry  = (r_state == ST_IDLE) && MC_MULTI && !w_mem_entry &&
                         i_hazard_mc_op_e && !r_mc_done;

    // FSM: state, latency down-counter and one-shot completion flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mc_done <= 1'b0;
        end else begin
            r_mc_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_entry) begin
                        r_state <= ST_MEM_WAIT;
                        r_cnt   <= MEM_LOAD;
                    end else if (w_mc_entry) begin
                        r_state <= ST_MC_BUSY;
                        r_cnt   <= MC_LOAD;
                    end
                end
                ST_MEM_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MC_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state   <= ST_IDLE;
                        r_mc_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall/flush decode; a redirect is only honoured when E is actually advancing.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_m = 1'b0;
        if ((r_state == ST_MEM_WAIT) || w_mem_entry) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
        end else if ((r_state == ST_MC_BUSY) || w_mc_entry) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
        end else if (i_hazard_branch_taken_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lwstall || w_raw_d) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles; clear has priority.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_stall_cnt <= '0;
        end else if (i_hazard_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_f && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_hazard_stall_f   = w_stall_f;
    assign o_hazard_stall_d   = w_stall_d;
    assign o_hazard_stall_e   = w_stall_e;
    assign o_hazard_stall_m   = w_stall_m;
    assign o_hazard_flush_d   = w_flush_d;
    assign o_hazard_flush_e   = w_flush_e;
    assign o_hazard_flush_m   = w_flush_m;
    assign o_hazard_mc_done   = r_mc_done;
    assign o_hazard_busy      = (r_state != ST_IDLE);
    assign o_hazard_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl_mc.sv
// Directed bench: one forwarding-enabled instance (MEM_LAT=3) and one forwarding-disabled instance (CNT_W=4).
module tb_riscv_hazard_ctrl_mc;

    logic       clk;
    logic       rstn;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       wr_e, load_e, mc_op, br, wr_m, mem_req, wr_w, cnt_clr;

    logic       sf, sd, se, sm, fd, fe, fm, done, busy;
    logic [1:0] fae, fbe;
    logic [31:0] scnt;
    logic       n_sf, n_sd, n_se, n_sm, n_fd, n_fe, n_fm, n_done, n_busy;
    logic [1:0] n_fae, n_fbe;
    logic [3:0] n_scnt;

    logic [6:0] ctl, n_ctl;
    assign ctl   = {sf, sd, se, sm, fd, fe, fm};
    assign n_ctl = {n_sf, n_sd, n_se, n_sm, n_fd, n_fe, n_fm};

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100010;
    localparam logic [6:0] C_MC   = 7'b1110001;
    localparam logic [6:0] C_MEM  = 7'b1111000;
    localparam logic [6:0] C_BR   = 7'b0000110;

    riscv_hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(8), .MEM_LAT(3), .FWD_EN(1), .CNT_W(32)) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_hazard_rs1_addr_d(rs1_d), .i_hazard_rs2_addr_d(rs2_d),
        .i_hazard_rs1_addr_e(rs1_e), .i_hazard_rs2_addr_e(rs2_e), .i_hazard_rd_addr_e(rd_e),
        .i_hazard_reg_wr_en_e(wr_e), .i_hazard_load_e(load_e), .i_hazard_mc_op_e(mc_op),
        .i_hazard_branch_taken_e(br), .i_hazard_rd_addr_m(rd_m), .i_hazard_reg_wr_en_m(wr_m),
        .i_hazard_mem_req_m(mem_req), .i_hazard_rd_addr_w(rd_w), .i_hazard_reg_wr_en_w(wr_w),
        .i_hazard_cnt_clr(cnt_clr),
        .o_hazard_stall_f(sf), .o_hazard_stall_d(sd), .o_hazard_stall_e(se), .o_hazard_stall_m(sm),
        .o_hazard_flush_d(fd), .o_hazard_flush_e(fe), .o_hazard_flush_m(fm),
        .o_hazard_forward_ae(fae), .o_hazard_forward_be(fbe),
        .o_hazard_mc_done(done), .o_hazard_busy(busy), .o_hazard_stall_cnt(scnt)
    );

    riscv_hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(8), .MEM_LAT(1), .FWD_EN(0), .CNT_W(4)) u_nf (
        .i_clk(clk), .i_rstn(rstn),
        .i_hazard_rs1_addr_d(rs1_d), .i_hazard_rs2_addr_d(rs2_d),
        .i_hazard_rs1_addr_e(rs1_e), .i_hazard_rs2_addr_e(rs2_e), .i_hazard_rd_addr_e(rd_e),
        .i_hazard_reg_wr_en_e(wr_e), .i_hazard_load_e(load_e), .i_hazard_mc_op_e(mc_op),
        .i_hazard_branch_taken_e(br), .i_hazard_rd_addr_m(rd_m), .i_hazard_reg_wr_en_m(wr_m),
        .i_hazard_mem_req_m(mem_req), .i_hazard_rd_addr_w(rd_w), .i_hazard_reg_wr_en_w(wr_w),
        .i_hazard_cnt_clr(cnt_clr),
        .o_hazard_stall_f(n_sf), .o_hazard_stall_d(n_sd), .o_hazard_stall_e(n_se), .o_hazard_stall_m(n_sm),
        .o_hazard_flush_d(n_fd), .o_hazard_flush_e(n_fe), .o_hazard_flush_m(n_fm),
        .o_hazard_forward_ae(n_fae), .o_hazard_forward_be(n_fbe),
        .o_hazard_mc_done(n_done), .o_hazard_busy(n_busy), .o_hazard_stall_cnt(n_scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        wr_e = 0; load_e = 0; mc_op = 0; br = 0; wr_m = 0; mem_req = 0; wr_w = 0; cnt_clr = 0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        clear_inputs();
        tick(); tick();
        checks++;
        if ({ctl, busy, done} !== 9'b0) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", {ctl, busy, done}, 9'b0);
        end
        checks++;
        if (scnt !== 32'd0 || n_scnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", scnt, n_scnt);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_forward;
        rs1_e = 5; rd_m = 5; wr_m = 1; rd_w = 5; wr_w = 1; #1;
        checks++;
        if (fae !== 2'b10) begin errors++; $display("FAIL fwd_m_prio: got %b expected 10", fae); end
        checks++;
        if (n_fae !== 2'b00) begin errors++; $display("FAIL fwd_dis_a: got %b expected 00", n_fae); end
        wr_m = 0; #1;
        checks++;
        if (fae !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b expected 01", fae); end
        wr_m = 1; rs1_e = 0; #1;
        checks++;
        if (fae !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b expected 00", fae); end
        rs2_e = 9; rd_m = 9; wr_m = 0; rd_w = 9; wr_w = 1; #1;
        checks++;
        if (fbe !== 2'b01) begin errors++; $display("FAIL fwd_b_w: got %b expected 01", fbe); end
        wr_m = 1; #1;
        checks++;
        if (fbe !== 2'b10) begin errors++; $display("FAIL fwd_b_m: got %b expected 10", fbe); end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use;
        load_e = 1; wr_e = 1; rd_e = 7; rs2_d = 7; #1;
        checks++;
        if (ctl !== C_LW) begin errors++; $display("FAIL lw_stall: got %b expected %b", ctl, C_LW); end
        tick();
        load_e = 0; wr_e = 0; rd_e = 0; #1;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lw_release: got %b expected %b", ctl, C_NONE); end
        load_e = 1; wr_e = 1; rd_e = 0; rs2_d = 0; #1;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lw_x0: got %b expected %b", ctl, C_NONE); end
        rd_e = 12; rs1_d = 12; #1;
        checks++;
        if (ctl !== C_LW) begin errors++; $display("FAIL lw_rs1: got %b expected %b", ctl, C_LW); end
        clear_inputs();
        tick();
    endtask

    task automatic test_mc_op;
        cnt_clr = 1; tick(); cnt_clr = 0;
        mc_op = 1; br = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({ctl, busy, done} !== {C_MC, (i != 0), 1'b0}) begin
                errors++;
                $display("FAIL mc_cycle%0d: got %b expected %b", i, {ctl, busy, done}, {C_MC, (i != 0), 1'b0});
            end
            tick();
        end
        br = 0; #1;
        checks++;
        if ({ctl, busy, done} !== {C_NONE, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mc_done_pulse: got %b expected %b", {ctl, busy, done}, {C_NONE, 2'b01});
        end
        mc_op = 0;
        tick();
        checks++;
        if ({ctl, busy, done} !== 9'b0) begin
            errors++; $display("FAIL mc_after: got %b expected %b", {ctl, busy, done}, 9'b0);
        end
        checks++;
        if (scnt !== 32'd8) begin errors++; $display("FAIL mc_stall_cnt: got %0d expected 8", scnt); end
    endtask

    task automatic test_mem_then_mc;
        clear_inputs();
        mem_req = 1; mc_op = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ctl, busy, done} !== {C_MEM, (i != 0), 1'b0}) begin
                errors++;
                $display("FAIL mem_cycle%0d: got %b expected %b", i, {ctl, busy, done}, {C_MEM, (i != 0), 1'b0});
            end
            tick();
        end
        mem_req = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({ctl, busy, done} !== {C_MC, (i != 0), 1'b0}) begin
                errors++;
                $display("FAIL memmc_cycle%0d: got %b expected %b", i, {ctl, busy, done}, {C_MC, (i != 0), 1'b0});
            end
            tick();
        end
        #1;
        checks++;
        if ({ctl, busy, done} !== {C_NONE, 1'b0, 1'b1}) begin
            errors++; $display("FAIL memmc_done: got %b expected %b", {ctl, busy, done}, {C_NONE, 2'b01});
        end
        mc_op = 0;
        tick();
    endtask

    task automatic test_branch_lw;
        clear_inputs();
        load_e = 1; wr_e = 1; rd_e = 7; rs2_d = 7; br = 1; #1;
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL br_lw: got %b expected %b", ctl, C_BR); end
        load_e = 0; #1;
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL br_only: got %b expected %b", ctl, C_BR); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_mc;
        clear_inputs();
        mc_op = 1;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_pre: got %b expected 1", busy); end
        mc_op = 0; rstn = 1'b0; #1;
        checks++;
        if ({ctl, busy, done} !== 9'b0) begin
            errors++; $display("FAIL rst_mid_abort: got %b expected %b", {ctl, busy, done}, 9'b0);
        end
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_nodone%0d: got %b expected 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_fwd_disable;
        clear_inputs();
        rs1_d = 3; rd_w = 3; wr_w = 1; rs1_e = 3; #1;
        checks++;
        if (n_ctl !== C_LW) begin errors++; $display("FAIL nf_raw_w: got %b expected %b", n_ctl, C_LW); end
        checks++;
        if ({n_fae, n_fbe} !== 4'b0000) begin errors++; $display("FAIL nf_fwd_zero: got %b expected 0000", {n_fae, n_fbe}); end
        checks++;
        if ({fae, ctl} !== {2'b01, C_NONE}) begin
            errors++; $display("FAIL fe_no_raw_stall: got %b expected %b", {fae, ctl}, {2'b01, C_NONE});
        end
        rs1_d = 0; rd_w = 0; wr_w = 0; rs2_d = 4; rd_m = 4; wr_m = 1; #1;
        checks++;
        if (n_ctl !== C_LW) begin errors++; $display("FAIL nf_raw_m: got %b expected %b", n_ctl, C_LW); end
        rd_m = 0; wr_m = 0; rs2_d = 6; rd_e = 6; wr_e = 1; #1;
        checks++;
        if (n_ctl !== C_LW) begin errors++; $display("FAIL nf_raw_e: got %b expected %b", n_ctl, C_LW); end
        rd_e = 0; wr_e = 0; rs2_d = 0; rs1_d = 0; rd_w = 0; wr_w = 1; #1;
        checks++;
        if (n_ctl !== C_NONE) begin errors++; $display("FAIL nf_x0: got %b expected %b", n_ctl, C_NONE); end
        clear_inputs();
        tick();
    endtask

    task automatic test_saturate;
        clear_inputs();
        rs1_d = 3; rd_w = 3; wr_w = 1; cnt_clr = 1;
        tick();
        cnt_clr = 0;
        repeat (14) tick();
        checks++;
        if (n_scnt !== 4'd14) begin errors++; $display("FAIL sat_count14: got %0d expected 14", n_scnt); end
        repeat (6) tick();
        checks++;
        if (n_scnt !== 4'd15) begin errors++; $display("FAIL sat_hold15: got %0d expected 15", n_scnt); end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        checks++;
        if (n_scnt !== 4'd0) begin errors++; $display("FAIL sat_clr_prio: got %0d expected 0", n_scnt); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mc_op();
        test_mem_then_mc();
        test_branch_lw();
        test_reset_mid_mc();
        test_fwd_disable();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
